// File: rtl/ftoi_sched_pkg.sv
// Shared FPU definitions: ftoi saturation constants and the request record
// carried through the ftoi scheduler pipeline (id/tag sized for the widest instance).
package ftoi_sched_pkg;

  localparam logic [31:0] FTOI_SAT_POS  = 32'h7FFFFFFF;
  localparam logic [31:0] FTOI_SAT_NEG  = 32'h80000000;
  localparam int          FTOI_ID_MAXW  = 3;
  localparam int          FTOI_TAG_MAXW = 16;

  typedef struct packed {
    logic [31:0]              f;
    logic [FTOI_ID_MAXW-1:0]  id;
    logic [FTOI_TAG_MAXW-1:0] tag;
  } ftoi_req_t;

endpackage

// File: rtl/ftoi.sv
// Float-to-int conversion, round half away from zero, saturating.
// Latency: combinational.
// Backpressure: none (pure function).
module ftoi
  import ftoi_sched_pkg::*;
(
  input  logic [31:0] f,
  output logic [31:0] i
);

  logic        sgn;
  logic [7:0]  e;
  logic [23:0] man;
  logic [4:0]  sh;
  logic [31:0] mag;
  logic [31:0] rnd;

  always_comb begin
    sgn = f[31];
    e   = f[30:23];
    man = {1'b1, f[22:0]};
    sh  = '0;
    rnd = '0;
    mag = '0;
    if (e >= 8'd158) begin
      mag = FTOI_SAT_POS;
    end else if (e >= 8'd150) begin
      sh  = 5'(e - 8'd150);
      mag = {8'd0, man} << sh;
    end else if (e >= 8'd126) begin
      // adding half an output LSB before truncating gives half-away-from-zero on the magnitude
      sh  = 5'(8'd150 - e);
      rnd = {8'd0, man} + (32'd1 << (sh - 5'd1));
      mag = rnd >> sh;
    end
    i = sgn ? (32'd0 - mag) : mag;
    if (sgn && e == 8'd158 && f[22:0] == 23'd0)
      i = FTOI_SAT_NEG;
  end

endmodule

// File: rtl/ftoi_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its accept.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic found;
  int   k;

  always_comb begin
    grant = '0;
    found = 1'b0;
    k     = 0;
    for (int n = 0; n < NREQ; n++) begin
      k = (int'(ptr) + n) % NREQ;
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ftoi_sched.sv
// Shares one ftoi between NREQ requesters, round-robin, tagged responses.
// Latency: 1 cycle, or 2 with FTOI_SCHED_INREG_EN (registered input stage).
// Backpressure: out_ready low with out_valid holds all full stages; an empty input stage still absorbs one request.
module ftoi_sched
  import ftoi_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*32-1:0]       req_f,
  input  logic [NREQ*TAGW-1:0]     req_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_i,
  output logic [$clog2(NREQ)-1:0]  out_id,
  output logic [TAGW-1:0]          out_tag,
  output logic [31:0]              done_cnt
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  gid;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic            adv;
  logic            hs;
  logic            cvt_valid;
  ftoi_req_t       mux_req;
  ftoi_req_t       cvt_req;
  logic [31:0]     cvt_i;
  logic            unused_bits;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr),
    .grant (grant)
  );

  always_comb begin
    gid     = '0;
    mux_req = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (grant[n]) begin
        gid         = IDW'(n);
        mux_req.f   = req_f[32*n +: 32];
        mux_req.id  = FTOI_ID_MAXW'(n);
        mux_req.tag = FTOI_TAG_MAXW'(req_tag[TAGW*n +: TAGW]);
      end
    end
  end

  assign adv       = !out_valid || out_ready;
  assign req_ready = rstn ? (grant & {NREQ{accept}}) : '0;
  assign hs        = |(req_valid & req_ready);

`ifdef FTOI_SCHED_INREG_EN
  logic      in_valid;
  ftoi_req_t in_req;

  assign accept    = !in_valid || adv;
  assign cvt_valid = in_valid;
  assign cvt_req   = in_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_valid <= 1'b0;
      in_req   <= '0;
    end else if (accept) begin
      in_valid <= hs;
      if (hs)
        in_req <= mux_req;
    end
  end
`else
  assign accept    = adv;
  assign cvt_valid = hs;
  assign cvt_req   = mux_req;
`endif

  ftoi u_ftoi (
    .f (cvt_req.f),
    .i (cvt_i)
  );

  // id/tag fields are sized for the widest instance; the upper bits are constant zero
  assign unused_bits = ^{cvt_req.id, cvt_req.tag};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_id    <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= cvt_valid;
      if (cvt_valid) begin
        out_i   <= cvt_i;
        out_id  <= cvt_req.id[IDW-1:0];
        out_tag <= cvt_req.tag[TAGW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr       <= '0;
      done_cnt <= '0;
    end else begin
      if (hs)
        rr <= (gid == IDW'(NREQ-1)) ? '0 : gid + IDW'(1);
      if (out_valid && out_ready)
        done_cnt <= done_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ftoi_sched.sv
// Scoreboard bench for ftoi_sched: requester drivers, rr/ftoi reference model, output monitor.
module tb_ftoi_sched;

  localparam int NREQ = 2;
  localparam int TAGW = 4;
`ifdef FTOI_SCHED_INREG_EN
  localparam int LAT = 2;
  localparam int STALL_ACC = 2;
`else
  localparam int LAT = 1;
  localparam int STALL_ACC = 1;
`endif

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_f;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_i;
  logic [0:0]           out_id;
  logic [TAGW-1:0]      out_tag;
  logic [31:0]          done_cnt;

  ftoi_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_f(req_f), .req_tag(req_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_id(out_id),
    .out_tag(out_tag), .done_cnt(done_cnt)
  );

  typedef struct { logic [31:0] f; logic [TAGW-1:0] tag; } src_t;
  typedef struct { logic [31:0] i; int id; logic [TAGW-1:0] tag; } exp_t;

  src_t        src_q[NREQ][$];
  exp_t        exp_q[$];
  int          grants[$];
  int          hcycles[$];
  bit          hs_seen[NREQ];
  bit          rand_mode = 0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hs_cyc = -1;
  int          hs_total = 0;
  int          model_rr = 0;
  logic [31:0] model_cnt = 0;
  logic [31:0] specials[8] = '{32'h3FC00000, 32'h40200000, 32'hC0200000, 32'h3F000000,
                               32'h4F000000, 32'hCF000000, 32'h3EFFFFFF, 32'h7F800000};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference conversion from the numeric value of the float.
  function automatic logic [31:0] ref_ftoi(input logic [31:0] f);
    int     e;
    real    mag;
    longint m;
    e = int'(f[30:23]);
    if (f == 32'hCF000000) return 32'h80000000;
    if (e >= 158) m = 64'h7FFFFFFF;
    else if (e == 0) m = 0;
    else begin
      mag = real'({1'b1, f[22:0]}) * (2.0 ** (e - 150));
      m = longint'($floor(mag + 0.5));
    end
    if (f[31]) m = -m;
    return m[31:0];
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r = specials[$urandom_range(0, 7)];
    else r[30:23] = 8'($urandom_range(110, 157));
    return r;
  endfunction

  function automatic void push(input int k, input logic [31:0] f, input logic [TAGW-1:0] tag);
    src_t s;
    s.f = f;
    s.tag = tag;
    src_q[k].push_back(s);
  endfunction

  // Requester drivers: present the next queued operand, hold it until its handshake.
  initial begin
    src_t s;
    req_valid = '0;
    req_f = '0;
    req_tag = '0;
    for (int k = 0; k < NREQ; k++) hs_seen[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin
        if (hs_seen[k]) begin
          req_valid[k] = 1'b0;
          hs_seen[k] = 0;
        end
        if (!req_valid[k] && src_q[k].size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
          s = src_q[k].pop_front();
          req_f[32*k +: 32] = s.f;
          req_tag[TAGW*k +: TAGW] = s.tag;
          req_valid[k] = 1'b1;
        end
      end
    end
  end

  // Monitor: samples just before each rising edge.
  initial begin
    logic          prev_stall;
    logic [31:0]   prev_i;
    logic [0:0]    prev_id;
    logic [TAGW-1:0] prev_tag;
    int            g, eg;
    exp_t          ex;
    prev_stall = 0;
    prev_i = '0;
    prev_id = '0;
    prev_tag = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rstn) begin
        exp_q.delete();
        model_rr = 0;
        model_cnt = 0;
        prev_stall = 0;
        continue;
      end
      check("ready_at_most_one", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_i", out_i, prev_i);
        check("stall_id", 32'(out_id), 32'(prev_id));
        check("stall_tag", 32'(out_tag), 32'(prev_tag));
      end
      if (|(req_valid & req_ready)) begin
        g = 0;
        for (int k = 0; k < NREQ; k++) if (req_valid[k] && req_ready[k]) g = k;
        eg = -1;
        for (int n = 0; n < NREQ; n++)
          if (eg < 0 && req_valid[(model_rr + n) % NREQ]) eg = (model_rr + n) % NREQ;
        check("rr_grant", g, eg);
        model_rr = (g + 1) % NREQ;
        grants.push_back(g);
        hcycles.push_back(cyc);
        hs_cyc = cyc;
        hs_total++;
        ex.i = ref_ftoi(req_f[32*g +: 32]);
        ex.id = g;
        ex.tag = req_tag[TAGW*g +: TAGW];
        exp_q.push_back(ex);
        hs_seen[g] = 1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
        else begin
          ex = exp_q.pop_front();
          check("out_i", out_i, ex.i);
          check("out_id", 32'(out_id), ex.id);
          check("out_tag", 32'(out_tag), 32'(ex.tag));
        end
      end
      check("done_cnt", done_cnt, model_cnt);
      if (out_valid && out_ready) model_cnt = model_cnt + 32'd1;
      prev_stall = out_valid && !out_ready;
      prev_i = out_i;
      prev_id = out_id;
      prev_tag = out_tag;
    end
  end

  task automatic wait_out();
    bit ok;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      #3;
      if (out_valid) ok = 1;
    end
    if (!ok) check("out_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
          req_valid == '0 && !out_valid) ok = 1;
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int h0, gr0, g0;
    rstn = 1'b0;
    out_ready = 1'b0;
    push(0, 32'h40200000, 4'd5);
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_i", out_i, 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_done_cnt", done_cnt, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // single request: 2.5 -> 3
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    wait_out();
    check("latency", cyc - hs_cyc, LAT);
    check("single_i", out_i, 32'd3);
    check("single_tag", 32'(out_tag), 32'd5);
    wait_drain();
    check("single_done", done_cnt, 32'd1);

    // move rr back to 0, then contention
    push(1, 32'h3F800000, 4'd1);
    wait_drain();
    g0 = grants.size();
    for (int n = 0; n < 4; n++) begin
      push(0, 32'hBFC00000, 4'(n));
      push(1, 32'h3F000000, 4'(8 + n));
    end
    wait_drain();
    for (int n = 0; n < 4; n++) check("contend_grant", grants[g0 + n], n % 2);
    for (int n = 0; n < 7; n++) check("contend_rate", hcycles[g0 + n + 1] - hcycles[g0 + n], 1);

    // saturation
    push(0, 32'h4F000000, 4'd2);
    push(1, 32'hCF000000, 4'd3);
    wait_drain();

    // backpressure from idle
    @(negedge clk);
    out_ready = 1'b0;
    h0 = hs_total;
    for (int n = 0; n < 3; n++) begin
      push(0, rand_op(), 4'($urandom));
      push(1, rand_op(), 4'($urandom));
    end
    repeat (7) @(negedge clk);
    #3;
    check("stall_accepts", hs_total - h0, STALL_ACC);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();

    // reset mid-stream
    for (int n = 0; n < 8; n++) begin
      push(0, rand_op(), 4'($urandom));
      push(1, rand_op(), 4'($urandom));
    end
    repeat (3) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_done_cnt", done_cnt, 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    gr0 = grants.size();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    wait_drain();
    check("post_rst_first_grant", grants[gr0], 0);

    // random traffic with random backpressure
    rand_mode = 1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NREQ; k++)
        if (src_q[k].size() < 3 && $urandom_range(0, 1) == 1) push(k, rand_op(), 4'($urandom));
    end
    @(negedge clk);
    out_ready = 1'b1;
    rand_mode = 0;
    wait_drain();

    // counter wrap
    @(negedge clk);
    out_ready = 1'b0;
    push(0, 32'h3FC00000, 4'd7);
    wait_out();
    @(negedge clk);
    #1;
    force dut.done_cnt = 32'hFFFFFFFF;
    #1;
    release dut.done_cnt;
    model_cnt = 32'hFFFFFFFF;
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();
    check("done_wrap", done_cnt, 32'd0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ftoi_sched.md
# ftoi_sched

Shares one float-to-int converter (`ftoi`) between `NREQ` requesters in the FPU cluster. Round-robin arbitration, valid/ready on both sides, one result register, optional input register stage. Results return on a single response channel tagged with requester index and caller tag. Throughput one conversion per cycle when unstalled.

## Interface
- `NREQ`, 2 — number of requesters, 2..8
- `TAGW`, 4 — caller tag width carried alongside each operand
- `clk` in 1 — clock
- `rstn` in 1 — asynchronous active-low reset
- `req_valid` in NREQ — per-requester operand valid
- `req_ready` out NREQ — per-requester accept; at most one bit high per cycle
- `req_f` in NREQ×32 — packed operands, requester k at bits [32k+31:32k]
- `req_tag` in NREQ×TAGW — packed tags
- `out_valid` out 1 — result valid
- `out_ready` in 1 — consumer accept
- `out_i` out 32 — converted integer, equal to `ftoi` output for the operand
- `out_id` out $clog2(NREQ) — index of originating requester
- `out_tag` out TAGW — tag of originating request
- `done_cnt` out 32 — count of completed output handshakes, wraps

## Operation
- Arbiter: round-robin pointer `rr`, reset 0. Grant goes to the first requester at or after `rr` (modulo NREQ) with `req_valid`. `req_ready[g]` = grant[g] && `accept`, where `accept` means the first pipeline stage can take data this cycle.
- After a handshake on requester g, `rr` becomes (g+1) mod NREQ. With no handshake, `rr` holds.
- `req_ready` may depend combinationally on `req_valid`. Requesters must not derive `req_valid` from `req_ready`. Once asserted, a requester holds `req_valid`, `req_f` and `req_tag` stable until its handshake.
- Conversion is the combinational `ftoi` instance. Its rules are unchanged: round half away from zero. Exponent ≥ 158 saturates magnitude to 0x7FFFFFFF. 0xCF000000 gives 0x80000000. Results below 0.5 in magnitude give 0.
- The result stage holds `out_valid`, `out_i`, `out_id` and `out_tag`. It advances when it is empty or `out_ready` is high.
- Stall: `out_valid` && !`out_ready`. In a stall, all valid stages hold their contents and `accept` = 0, except an empty input stage (see Configuration).
- `done_cnt` increments on each `out_valid` && `out_ready` cycle. It wraps from 0xFFFFFFFF to 0.
- Reset: asserting `rstn` low at any time clears every stage valid, `rr`, and `done_cnt` immediately. In-flight requests are dropped and are not replayed.
- Reset values: `out_valid` 0, `out_i` 0, `out_id` 0, `out_tag` 0, `done_cnt` 0. `req_ready` is all 0 while `rstn` is low.

## Timing
- Latency without input stage: handshake at edge N → `out_valid` high in the cycle after edge N (1 cycle).
- Latency with input stage: 2 cycles.
- With `out_ready` held high, a result is produced every cycle and `accept` stays 1.
- Handshakes on the same edge: an output handshake and a request handshake on the same edge are both legal. The result stage reloads with no bubble.
- `out_ready` deasserted with `out_valid` high: outputs stay stable until the handshake.

## Configuration
- `FTOI_SCHED_INREG_EN` defined:
  - A registered input stage holding operand, id and tag sits in front of `ftoi`.
  - `accept` = input stage empty || result stage advances.
  - One request can still be absorbed during a stall if the input stage is empty.
  - Latency 2.
- Not defined:
  - Operand, id and tag feed `ftoi` directly from the arbiter mux.
  - `accept` = result stage empty || `out_ready`.
  - Latency 1.

## Structure
- Shared FPU package holds the following; per-instance parameters stay in the module:
  - the saturation constants 32'h7FFFFFFF and 32'h80000000
  - the `ftoi_req_t` struct: operand, id, tag
- One sub-module, `rr_arbiter`: NREQ request vector and pointer in, one-hot grant out. `ftoi` is instantiated unchanged.

## Test plan
- Single request: requester 0 sends 0x40200000 (2.5), tag 5, `out_ready` = 1.
  - Expect `out_i` = 3, `out_id` = 0, `out_tag` = 5 after 1 cycle, or 2 cycles with INREG.
  - `done_cnt` = 1.
- Contention: both requesters valid continuously with `rr` = 0. Requester 0 sends 0xBFC00000 (−1.5), requester 1 sends 0x3F000000 (0.5).
  - Grants alternate 0,1,0,1.
  - Outputs alternate 0xFFFFFFFE and 0x00000001, one per cycle.
- Saturation: operands 0x4F000000 and 0xCF000000 → 0x7FFFFFFF and 0x80000000.
- Backpressure:
  - Hold `out_ready` = 0 for 5 cycles with both requesters active.
  - `out_*` stays stable. With INREG exactly one extra request is accepted, without INREG none.
  - After release, results come in grant order with no loss or duplication.
- Reset mid-stream: drop `rstn` while 2 results are in flight.
  - `out_valid` falls immediately, `done_cnt` = 0.
  - After release the first grant goes to requester 0.
- Counter wrap: force `done_cnt` to 0xFFFFFFFF, then complete one handshake → `done_cnt` = 0.
